// File: rtl/dat_pkg.sv
// Shared types and constants for the DAT transfer sequencer.
package dat_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitRdy,
        StLaunch,
        StWaitDone,
        StNext,
        StAbortWait,
        StFinish
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ABORT   = 2'd2;
    localparam logic [1:0] ERR_BADREQ  = 2'd3;

    // Bits needed to count 0..max_retries inclusive.
    function automatic int unsigned retry_w(input int unsigned max_retries);
        return (max_retries == 0) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/dat_service_ctrl_if.sv
// Host-request, FIFO-status and DAT-engine signals of the transfer sequencer.
interface dat_service_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             reqWriteRead;
    logic [CNT_W-1:0] reqBlockCount;
    logic [3:0]       reqBlockSize;
    logic [15:0]      reqTimeout;
    logic             reqTimeoutEnable;
    logic             fifoEmpty;
    logic             fifo_full;
    logic             IDLE_out;
    logic             complete;
    logic             timeOutFail;
    logic             newService;
    logic             writeRead;
    logic             multiblock;
    logic [3:0]       blockSize;
    logic [15:0]      timeout;
    logic             timeoutenable;
    logic             busy;
    logic             done;
    logic [1:0]       errorCode;
    logic [CNT_W-1:0] blocksDone;

    modport master (
        output start, abort, reqWriteRead, reqBlockCount, reqBlockSize, reqTimeout,
               reqTimeoutEnable, fifoEmpty, fifo_full, IDLE_out, complete, timeOutFail,
        input  newService, writeRead, multiblock, blockSize, timeout, timeoutenable, busy,
               done, errorCode, blocksDone
    );

    modport slave (
        input  start, abort, reqWriteRead, reqBlockCount, reqBlockSize, reqTimeout,
               reqTimeoutEnable, fifoEmpty, fifo_full, IDLE_out, complete, timeOutFail,
        output newService, writeRead, multiblock, blockSize, timeout, timeoutenable, busy,
               done, errorCode, blocksDone
    );

endinterface

// File: rtl/dat_block_counter.sv
// Remaining-block, completed-block and per-block retry counters for one transfer.
module dat_block_counter
    import dat_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MAX_RETRIES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_count,
    input  logic             block_ok,
    input  logic             retry,
    output logic [CNT_W-1:0] blocks_done,
    output logic             last,
    output logic             exhausted,
    output logic             multi_next
);

    localparam int unsigned       RetryW   = retry_w(MAX_RETRIES);
    localparam logic [CNT_W-1:0]  CntMax   = '1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);

    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]  blocks_done_q, blocks_done_d;
    logic [RetryW-1:0] retry_q, retry_d;

    always_comb begin
        remaining_d   = remaining_q;
        blocks_done_d = blocks_done_q;
        retry_d       = retry_q;
        if (load) begin
            remaining_d   = load_count;
            blocks_done_d = '0;
            retry_d       = '0;
        end else if (block_ok) begin
            if (remaining_q != '0) remaining_d = remaining_q - CNT_W'(1);
            if (blocks_done_q != CntMax) blocks_done_d = blocks_done_q + CNT_W'(1);
            retry_d = '0;
        end else if (retry && (retry_q != RetryMax)) begin
            retry_d = retry_q + RetryW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining_q   <= '0;
            blocks_done_q <= '0;
            retry_q       <= '0;
        end else begin
            remaining_q   <= remaining_d;
            blocks_done_q <= blocks_done_d;
            retry_q       <= retry_d;
        end
    end

    assign blocks_done = blocks_done_q;
    assign last        = (remaining_q == '0);
    assign exhausted   = (retry_q >= RetryMax);
    // Lets the owner register multiblock in step with the remaining count.
    assign multi_next  = (remaining_d > CNT_W'(1));

endmodule

// File: rtl/dat_service_ctrl.sv
// Multi-block transfer sequencer: launches one DAT service per block, retries timeouts.
module dat_service_ctrl
    import dat_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MAX_RETRIES = 2
) (
    input  logic               clock,
    input  logic               reset,
    dat_service_ctrl_if.slave  bus
);

    state_e      state_q, state_d;
    logic [1:0]  err_q, err_d;
    logic        wr_q;
    logic [3:0]  bs_q;
    logic [15:0] tov_q;
    logic        te_q;
    logic        new_service_q, busy_q, done_q, multiblock_q;
    logic        load, block_ok, retry;
    logic        last, exhausted, multi_next;
    logic        fifo_ready;

    dat_block_counter #(
        .CNT_W       (CNT_W),
        .MAX_RETRIES (MAX_RETRIES)
    ) u_counter (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .load_count  (bus.reqBlockCount),
        .block_ok    (block_ok),
        .retry       (retry),
        .blocks_done (bus.blocksDone),
        .last        (last),
        .exhausted   (exhausted),
        .multi_next  (multi_next)
    );

    assign fifo_ready = wr_q ? !bus.fifoEmpty : !bus.fifo_full;

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        load     = 1'b0;
        block_ok = 1'b0;
        retry    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    load = 1'b1;
                    if (bus.reqBlockCount == '0) begin
                        err_d   = ERR_BADREQ;
                        state_d = StFinish;
                    end else begin
                        err_d   = ERR_NONE;
                        state_d = StWaitRdy;
                    end
                end
            end
            StWaitRdy: if (bus.IDLE_out && fifo_ready) state_d = StLaunch;
            StLaunch:  state_d = StWaitDone;
            StWaitDone: begin
                // Timeout wins over a simultaneous complete.
                if (bus.timeOutFail) begin
                    if (exhausted) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = StFinish;
                    end else begin
                        retry   = 1'b1;
                        state_d = StWaitRdy;
                    end
                end else if (bus.complete) begin
                    block_ok = 1'b1;
                    state_d  = StNext;
                end
            end
            StNext: state_d = last ? StFinish : StWaitRdy;
            StAbortWait: begin
                if (bus.IDLE_out) begin
                    err_d   = ERR_ABORT;
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (bus.abort && (state_q inside {StWaitRdy, StLaunch, StWaitDone, StNext})) begin
            state_d  = StAbortWait;
            err_d    = err_q;
            block_ok = 1'b0;
            retry    = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            err_q         <= ERR_NONE;
            wr_q          <= 1'b0;
            bs_q          <= '0;
            tov_q         <= '0;
            te_q          <= 1'b0;
            new_service_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            multiblock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (load) begin
                wr_q  <= bus.reqWriteRead;
                bs_q  <= bus.reqBlockSize;
                tov_q <= bus.reqTimeout;
                te_q  <= bus.reqTimeoutEnable;
            end
            new_service_q <= (state_d == StLaunch);
            busy_q        <= (state_d != StIdle);
            done_q        <= (state_d == StFinish);
            multiblock_q  <= (state_d != StIdle) && multi_next;
        end
    end

    assign bus.newService    = new_service_q;
    assign bus.writeRead     = wr_q;
    assign bus.blockSize     = bs_q;
    assign bus.timeout       = tov_q;
    assign bus.timeoutenable = te_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.multiblock    = multiblock_q;
    assign bus.errorCode     = err_q;

endmodule

// File: tb/tb_dat_service_ctrl.sv
// Self-checking bench for dat_service_ctrl with a small behavioural DAT engine.
module tb_dat_service_ctrl;

    logic clock;
    logic rst_n;
    int   checks;
    int   failures;

    dat_service_ctrl_if #(.CNT_W(16)) bus ();

    dat_service_ctrl #(
        .CNT_W       (16),
        .MAX_RETRIES (2)
    ) dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Engine model configuration, written by the main sequence.
    int dat_delay;
    int tmo_until;
    int both_at;

    // Engine model state, written only by the engine process.
    int   launches;
    int   fires;
    int   cnt;
    bit   quiet;
    logic mb_q[$];

    // DAT engine: busy for dat_delay cycles after each launch, then complete or timeout.
    initial begin
        launches     = 0;
        fires        = 0;
        cnt          = 0;
        quiet        = 1'b0;
        bus.IDLE_out    = 1'b1;
        bus.complete    = 1'b0;
        bus.timeOutFail = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            bus.complete    = 1'b0;
            bus.timeOutFail = 1'b0;
            if (!rst_n) begin
                cnt          = 0;
                quiet        = 1'b0;
                bus.IDLE_out = 1'b1;
            end else if (bus.newService) begin
                mb_q.push_back(bus.multiblock);
                launches++;
                cnt          = dat_delay;
                quiet        = 1'b0;
                bus.IDLE_out = 1'b0;
            end else if (bus.abort && cnt != 0) begin
                cnt   = 10;
                quiet = 1'b1;
            end else if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.IDLE_out = 1'b1;
                    if (!quiet) begin
                        if (fires < tmo_until) begin
                            bus.timeOutFail = 1'b1;
                            if (fires == both_at) bus.complete = 1'b1;
                        end else begin
                            bus.complete = 1'b1;
                        end
                        fires++;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] cnt;
        logic [3:0]  bs;
        logic [15:0] tov;
        logic        te;
        int          delay;
        int          tmo;
        logic        both;
        int          hold;
        int          abort_at;
        int          done_n;
        int          exp_launch;
        logic [7:0]  exp_mb;
        logic [1:0]  exp_err;
        logic [15:0] exp_bd;
    } case_t;

    case_t cases [7];

    task automatic run_case(input int idx);
        case_t      c;
        int         base;
        bit         seen;
        bit         aborted;
        int         got_done_n;
        int         abort_n;
        logic [7:0] got_mb;
        c    = cases[idx];
        base = launches;
        dat_delay = c.delay;
        tmo_until = fires + c.tmo;
        both_at   = c.both ? fires : -1;
        bus.reqWriteRead     = c.wr;
        bus.reqBlockCount    = c.cnt;
        bus.reqBlockSize     = c.bs;
        bus.reqTimeout       = c.tov;
        bus.reqTimeoutEnable = c.te;
        // The FIFO flag of the other direction is held in its blocking state.
        bus.fifoEmpty = c.wr ? (c.hold > 0) : 1'b1;
        bus.fifo_full = c.wr ? 1'b1 : (c.hold > 0);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check($sformatf("c%0d busy", idx), 32'(bus.busy), 32'd1);
        check($sformatf("c%0d writeRead", idx), 32'(bus.writeRead), 32'(c.wr));
        check($sformatf("c%0d blockSize", idx), 32'(bus.blockSize), 32'(c.bs));
        check($sformatf("c%0d timeout", idx), 32'(bus.timeout), 32'(c.tov));
        check($sformatf("c%0d timeoutenable", idx), 32'(bus.timeoutenable), 32'(c.te));
        seen       = 1'b0;
        aborted    = 1'b0;
        got_done_n = -1;
        abort_n    = -1;
        for (int n = 0; n < 3000 && !seen; n++) begin
            bus.abort = 1'b0;
            if (c.hold > 0 && n == c.hold) begin
                check($sformatf("c%0d no_launch_while_fifo_blocked", idx),
                      32'(launches - base), 32'd0);
                if (c.wr) bus.fifoEmpty = 1'b0;
                else      bus.fifo_full = 1'b0;
            end
            if (c.abort_at > 0 && !aborted && (launches - base) == c.abort_at) begin
                bus.abort = 1'b1;
                aborted   = 1'b1;
                abort_n   = n;
            end
            if (bus.done) begin
                seen       = 1'b1;
                got_done_n = n;
            end else begin
                @(negedge clock);
            end
        end
        bus.abort = 1'b0;
        check($sformatf("c%0d done_seen", idx), 32'(seen), 32'd1);
        check($sformatf("c%0d launches", idx), 32'(launches - base), 32'(c.exp_launch));
        got_mb = '0;
        for (int i = 0; i < c.exp_launch && i < 8; i++)
            if (base + i < mb_q.size()) got_mb[i] = mb_q[base + i];
        check($sformatf("c%0d multiblock_at_launch", idx), 32'(got_mb), 32'(c.exp_mb));
        if (seen) begin
            check($sformatf("c%0d errorCode", idx), 32'(bus.errorCode), 32'(c.exp_err));
            check($sformatf("c%0d blocksDone", idx), 32'(bus.blocksDone), 32'(c.exp_bd));
            if (c.done_n >= 0)
                check($sformatf("c%0d done_latency", idx), 32'(got_done_n), 32'(c.done_n));
            if (aborted)
                check($sformatf("c%0d abort_waits_engine_idle", idx),
                      32'(got_done_n - abort_n >= 10), 32'd1);
            @(negedge clock);
            check($sformatf("c%0d done_one_cycle", idx), 32'(bus.done), 32'd0);
            check($sformatf("c%0d idle_busy", idx), 32'(bus.busy), 32'd0);
            check($sformatf("c%0d idle_multiblock", idx), 32'(bus.multiblock), 32'd0);
            check($sformatf("c%0d errorCode_held", idx), 32'(bus.errorCode), 32'(c.exp_err));
        end
    endtask

    initial begin
        int base;
        checks   = 0;
        failures = 0;
        dat_delay = 20;
        tmo_until = 0;
        both_at   = -1;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.reqWriteRead     = 1'b0;
        bus.reqBlockCount    = '0;
        bus.reqBlockSize     = '0;
        bus.reqTimeout       = '0;
        bus.reqTimeoutEnable = 1'b0;
        bus.fifoEmpty        = 1'b1;
        bus.fifo_full        = 1'b0;

        //            wr    cnt     bs    tov       te    dly tmo both  hold ab dn  nl mb       err   bd
        cases[0] = '{1'b1, 16'd3, 4'd9, 16'h1234, 1'b1, 20, 0,  1'b0, 0,   0, -1, 3, 8'b011,  2'd0, 16'd3};
        cases[1] = '{1'b0, 16'd1, 4'd2, 16'h00ff, 1'b0, 20, 0,  1'b0, 50,  0, -1, 1, 8'b0,    2'd0, 16'd1};
        cases[2] = '{1'b1, 16'd2, 4'd5, 16'h0040, 1'b1, 5,  99, 1'b0, 0,   0, -1, 3, 8'b111,  2'd1, 16'd0};
        cases[3] = '{1'b0, 16'd4, 4'd7, 16'hbeef, 1'b1, 20, 0,  1'b0, 0,   2, -1, 2, 8'b11,   2'd2, 16'd1};
        cases[4] = '{1'b1, 16'd1, 4'd1, 16'h0003, 1'b0, 3,  1,  1'b1, 0,   0, -1, 2, 8'b00,   2'd0, 16'd1};
        cases[5] = '{1'b0, 16'd0, 4'd3, 16'h5555, 1'b1, 20, 0,  1'b0, 0,   0, 0,  0, 8'b0,    2'd3, 16'd0};
        cases[6] = '{1'b1, 16'd2, 4'd4, 16'h0a0a, 1'b0, 4,  0,  1'b0, 15,  0, -1, 2, 8'b01,   2'd0, 16'd2};

        repeat (3) @(negedge clock);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset newService", 32'(bus.newService), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset multiblock", 32'(bus.multiblock), 32'd0);
        check("reset errorCode", 32'(bus.errorCode), 32'd0);
        check("reset blocksDone", 32'(bus.blocksDone), 32'd0);
        check("reset config", 32'({bus.writeRead, bus.blockSize, bus.timeout, bus.timeoutenable}),
              32'd0);
        rst_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 7; i++) run_case(i);

        // Reset while the second block is in flight.
        base = launches;
        dat_delay = 5;
        tmo_until = fires;
        both_at   = -1;
        bus.reqWriteRead  = 1'b1;
        bus.reqBlockCount = 16'd3;
        bus.fifoEmpty     = 1'b0;
        bus.fifo_full     = 1'b0;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        for (int k = 0; k < 500 && (launches - base) < 2; k++) @(negedge clock);
        check("rst_mid launches_before", 32'(launches - base), 32'd2);
        @(negedge clock);
        check("rst_mid blocksDone_before", 32'(bus.blocksDone), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid busy", 32'(bus.busy), 32'd0);
        check("rst_mid newService", 32'(bus.newService), 32'd0);
        check("rst_mid blocksDone", 32'(bus.blocksDone), 32'd0);
        check("rst_mid multiblock", 32'(bus.multiblock), 32'd0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        run_case(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
